// File: rtl/serializador_p2s.sv
// Parallel-to-serial frame transmitter: comma burst after reset, then data or idle bytes, MSB first.
// Optional build macro PARITY_EN appends an even-parity bit to every frame (9-bit frames).
module serializador_p2s #(
    parameter int unsigned SYNC_COUNT = 4,
    parameter logic [7:0]  COM_CHAR   = 8'hBC,
    parameter logic [7:0]  IDLE_CHAR  = 8'h7C
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       load_strobe,
    output logic       synced
);

`ifdef PARITY_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif
    localparam logic [3:0]         LAST_BIT  = 4'(FRAME_LEN - 1);
    localparam int unsigned        SC_W      = $clog2(SYNC_COUNT + 1);
    localparam logic [SC_W-1:0]    LAST_SYNC = SC_W'(SYNC_COUNT - 1);

    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

`ifdef PARITY_EN
    function automatic logic even_parity(input logic [7:0] byte_v);
        return ^byte_v;
    endfunction
`endif

    state_t                 state_r, state_nxt_s;
    logic [SC_W-1:0]        sync_cnt_r, sync_cnt_nxt_s;
    logic [3:0]             bit_cnt_r, bit_cnt_nxt_s;
    logic [FRAME_LEN-1:0]   shreg_r, shreg_nxt_s;
    logic                   data_out_r, data_out_nxt_s;
    logic                   load_strobe_r, load_strobe_nxt_s;
    logic                   synced_r, synced_nxt_s;
    logic [7:0]             frame_byte_s;
    logic [FRAME_LEN-1:0]   frame_bits_s;

    // Select the byte to transmit in the frame starting at this edge.
    always_comb begin
        frame_byte_s = COM_CHAR;
        case (state_r)
            ST_SYNC: begin
                frame_byte_s = COM_CHAR;
            end
            ST_ACTIVE: begin
                if (valid_in) begin
                    frame_byte_s = data_in;
                end else begin
                    frame_byte_s = IDLE_CHAR;
                end
            end
            default: begin
                frame_byte_s = COM_CHAR;
            end
        endcase
    end

`ifdef PARITY_EN
    assign frame_bits_s = {frame_byte_s, even_parity(frame_byte_s)};
`else
    assign frame_bits_s = frame_byte_s;
`endif

    // Frame sequencing: load on the last bit slot, otherwise shift out the next bit.
    always_comb begin
        state_nxt_s       = state_r;
        sync_cnt_nxt_s    = sync_cnt_r;
        bit_cnt_nxt_s     = bit_cnt_r;
        shreg_nxt_s       = shreg_r;
        data_out_nxt_s    = data_out_r;
        load_strobe_nxt_s = 1'b0;
        if (bit_cnt_r == LAST_BIT) begin
            load_strobe_nxt_s = 1'b1;
            bit_cnt_nxt_s     = 4'd0;
            data_out_nxt_s    = frame_bits_s[FRAME_LEN-1];
            shreg_nxt_s       = {frame_bits_s[FRAME_LEN-2:0], 1'b0};
            case (state_r)
                ST_SYNC: begin
                    sync_cnt_nxt_s = sync_cnt_r + SC_W'(1);
                    if (sync_cnt_r == LAST_SYNC) begin
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        state_nxt_s = ST_SYNC;
                    end
                end
                ST_ACTIVE: begin
                    // Counter stays parked at SYNC_COUNT once aligned.
                    sync_cnt_nxt_s = sync_cnt_r;
                    state_nxt_s    = ST_ACTIVE;
                end
                default: begin
                    sync_cnt_nxt_s = '0;
                    state_nxt_s    = ST_SYNC;
                end
            endcase
        end else begin
            bit_cnt_nxt_s  = bit_cnt_r + 4'd1;
            data_out_nxt_s = shreg_r[FRAME_LEN-1];
            shreg_nxt_s    = {shreg_r[FRAME_LEN-2:0], 1'b0};
        end
        synced_nxt_s = (state_nxt_s == ST_ACTIVE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_r       <= ST_SYNC;
            sync_cnt_r    <= '0;
            bit_cnt_r     <= LAST_BIT;
            shreg_r       <= '0;
            data_out_r    <= 1'b0;
            load_strobe_r <= 1'b0;
            synced_r      <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            sync_cnt_r    <= sync_cnt_nxt_s;
            bit_cnt_r     <= bit_cnt_nxt_s;
            shreg_r       <= shreg_nxt_s;
            data_out_r    <= data_out_nxt_s;
            load_strobe_r <= load_strobe_nxt_s;
            synced_r      <= synced_nxt_s;
        end
    end

    assign data_out    = data_out_r;
    assign load_strobe = load_strobe_r;
    assign synced      = synced_r;

endmodule

// File: tb/tb_serializador_p2s.sv
// Scoreboard bench for serializador_p2s: a frame-level model predicts each frame at its load
// edge; a monitor checks the serial bits, strobe spacing and synced against the queued frames.
module tb_serializador_p2s;

`ifdef PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    localparam int SYNC_COUNT = 4;

    typedef struct packed {
        logic [8:0] bits;
        logic       sync;
    } frame_t;

    logic       clk_8f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       data_out, load_strobe, synced;

    int     checks = 0;
    int     failures = 0;
    frame_t exp_q[$];
    int     since_rel = 0;
    bit     reset_edge = 1'b0;
    int     scenario = 0;

    serializador_p2s dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out),
        .load_strobe (load_strobe),
        .synced      (synced)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: model the edge that just happened, then drive inputs for the next edge.
    task automatic tick(input bit rst_nxt);
        frame_t     fr;
        int         fno;
        int         nf;
        logic [7:0] b;
        @(posedge clk_8f);
        #1;
        if (reset) begin
            exp_q.delete();
            since_rel  = 0;
            reset_edge = 1'b1;
        end else begin
            reset_edge = 1'b0;
            if (since_rel % FL == 0) begin
                fno = since_rel / FL + 1;
                if (fno <= SYNC_COUNT) b = 8'hBC;
                else if (valid_in)     b = data_in;
                else                   b = 8'h7C;
`ifdef PARITY_EN
                fr.bits = {b, ^b};
`else
                fr.bits = {1'b0, b};
`endif
                fr.sync = (fno >= SYNC_COUNT);
                exp_q.push_back(fr);
            end
            since_rel++;
        end
        reset = rst_nxt;
        nf = since_rel / FL + 1;
        if (scenario == 1) begin
            valid_in = 1'b1; data_in = 8'hA5;
        end else if (nf == 2 || nf == 3) begin
            valid_in = 1'b1; data_in = 8'hFF;
        end else if (nf == 5) begin
            valid_in = 1'b1; data_in = 8'hA5;
        end else if (nf == 6) begin
            valid_in = 1'b0; data_in = 8'($urandom);
        end else begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
        end
    endtask

    frame_t cur;
    int     idx = 0;
    bit     in_frame = 1'b0;
    int     gap = 0;
    bit     armed = 1'b0;

    // Monitor: sample outputs mid-cycle and compare against queued frames.
    always @(negedge clk_8f) begin
        if (reset_edge) begin
            armed    = 1'b1;
            in_frame = 1'b0;
            gap      = FL - 1;
            check("reset_out", {29'd0, data_out, load_strobe, synced}, 32'd0);
        end else if (armed) begin
            if (load_strobe === 1'b1) begin
                check("strobe_gap", gap, FL - 1);
                gap = 0;
                check("frame_queued", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur      = exp_q.pop_front();
                    idx      = 0;
                    in_frame = 1'b1;
                end else begin
                    in_frame = 1'b0;
                end
            end else begin
                gap++;
            end
            if (in_frame && idx < FL) begin
                check("data_bit", data_out, cur.bits[FL-1-idx]);
                check("synced", synced, cur.sync);
                idx++;
                if (idx == FL) in_frame = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        for (int i = 0; i < FL * 25; i++) tick(1'b0);
        // Abort an A5 frame part way through with a reset.
        scenario = 1;
        for (int i = 0; i < FL; i++) tick(1'b0);
        while (since_rel % FL != 3) tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        scenario = 0;
        tick(1'b0);
        for (int i = 0; i < FL * 8; i++) tick(1'b0);
        @(negedge clk_8f);
        #1;
        check("queue_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
